player_motion: RTL and testbench

Parametrised player movement controller for the game sprite. It takes held-key levels from the keyboard decoder and produces registered sprite coordinates for the draw pipeline. It supports walking in both directions with clamped screen bounds, edge-triggered jumps of fixed height, and gravity fall back to the floor. Horizontal steering works while airborne.

---
 rtl/player_motion.sv | 167 ++++++++++++++++
 tb/tb_player_motion.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/player_motion.sv
// Player movement controller: turns held-key levels into registered sprite
// coordinates. Walking in both directions with clamped bounds, edge-triggered
// fixed-height jumps and gravity fall back to the floor. Horizontal steering
// stays live while airborne.
//
// state  | meaning
// -------+--------------------------------------------
// GROUND | on the floor, idle or walking
// JUMP   | rising, one pixel every JUMP_DIV cycles
// FALL   | descending, one pixel every FALL_DIV cycles
module player_motion #(
  parameter int POS_W       = 12,
  parameter int STEP_DIV    = 80000,
  parameter int JUMP_DIV    = 60000,
  parameter int FALL_DIV    = 60000,
  parameter int JUMP_HEIGHT = 40,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 1000,
  parameter int X_INIT      = 0,
  parameter int Y_FLOOR     = 700
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_left,
  input  logic             key_right,
  input  logic             key_jump,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos,
  output logic             dir,
  output logic             airborne
);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    JUMP   = 2'd1,
    FALL   = 2'd2
  } state_t;

  localparam int V_MAX = (JUMP_DIV > FALL_DIV) ? JUMP_DIV : FALL_DIV;
  localparam int H_W   = $clog2(STEP_DIV);
  localparam int V_W   = $clog2(V_MAX);
  localparam int R_W   = $clog2(JUMP_HEIGHT + 1);

  localparam logic [H_W-1:0]   H_LAST     = H_W'(STEP_DIV - 1);
  localparam logic [V_W-1:0]   JUMP_LAST  = V_W'(JUMP_DIV - 1);
  localparam logic [V_W-1:0]   FALL_LAST  = V_W'(FALL_DIV - 1);
  localparam logic [R_W-1:0]   RISE_LAST  = R_W'(JUMP_HEIGHT - 1);
  localparam logic [POS_W-1:0] X_MIN_P    = POS_W'(X_MIN);
  localparam logic [POS_W-1:0] X_MAX_P    = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] X_INIT_P   = POS_W'(X_INIT);
  localparam logic [POS_W-1:0] Y_FLOOR_P  = POS_W'(Y_FLOOR);
  localparam logic [POS_W-1:0] Y_LAND_P   = POS_W'(Y_FLOOR - 1);

  state_t            state;
  state_t            state_next;
  logic [H_W-1:0]    h_cnt;
  logic [V_W-1:0]    v_cnt;
  logic [V_W-1:0]    v_cnt_next;
  logic [R_W-1:0]    rise;
  logic [R_W-1:0]    rise_next;
  logic [POS_W-1:0]  ypos_next;
  logic              jump_q;
  logic              jump_armed;
  logic              jump_edge;
  logic              mv;
  logic              h_wrap;

  assign mv     = key_left ^ key_right;
  assign h_wrap = mv && (h_cnt == H_LAST);

  // Horizontal walking: step divider, clamped x update, facing direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      xpos  <= X_INIT_P;
      dir   <= 1'b1;
    end else if (!mv) begin
      h_cnt <= '0;
    end else begin
      dir <= key_right;
      if (h_wrap) begin
        h_cnt <= '0;
        if (key_right) begin
          if (xpos < X_MAX_P) xpos <= xpos + 1'b1;
        end else begin
          if (xpos > X_MIN_P) xpos <= xpos - 1'b1;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Jump key history. A key still held across reset release must be let go
  // before it can start a jump, so the detector is armed only after a low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jump_q     <= 1'b0;
      jump_armed <= 1'b0;
    end else begin
      jump_q     <= key_jump;
      jump_armed <= jump_armed | ~key_jump;
    end
  end

  assign jump_edge = key_jump & ~jump_q & jump_armed;

  // Vertical FSM register plus the registered airborne flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= GROUND;
      v_cnt    <= '0;
      rise     <= '0;
      ypos     <= Y_FLOOR_P;
      airborne <= 1'b0;
    end else begin
      state    <= state_next;
      v_cnt    <= v_cnt_next;
      rise     <= rise_next;
      ypos     <= ypos_next;
      airborne <= (state_next != GROUND);
    end
  end

  // Vertical next-state: jump launch, rise with apex detect, fall with landing.
  always_comb begin
    state_next = state;
    v_cnt_next = v_cnt;
    rise_next  = rise;
    ypos_next  = ypos;
    case (state)
      GROUND: begin
        if (jump_edge) begin
          state_next = JUMP;
          v_cnt_next = '0;
          rise_next  = '0;
        end
      end
      JUMP: begin
        if (v_cnt == JUMP_LAST) begin
          v_cnt_next = '0;
          ypos_next  = ypos - 1'b1;
          rise_next  = rise + 1'b1;
          if (rise == RISE_LAST) state_next = FALL;
        end else begin
          v_cnt_next = v_cnt + 1'b1;
        end
      end
      FALL: begin
        if (v_cnt == FALL_LAST) begin
          v_cnt_next = '0;
          ypos_next  = ypos + 1'b1;
          if (ypos == Y_LAND_P) state_next = GROUND;
        end else begin
          v_cnt_next = v_cnt + 1'b1;
        end
      end
      default: begin
        state_next = GROUND;
        v_cnt_next = '0;
        rise_next  = '0;
        ypos_next  = Y_FLOOR_P;
      end
    endcase
  end

endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: a time-based reference model (elapsed walking
// edges and elapsed air time mapped to positions) compared on every falling
// clock edge, plus literal expectations at the scenario milestones.
module tb_player_motion;

  localparam int POS_W = 12;
  localparam int SD    = 4;
  localparam int JD    = 2;
  localparam int FD    = 3;
  localparam int JH    = 5;
  localparam int XMIN  = 10;
  localparam int XMAX  = 20;
  localparam int XINIT = 12;
  localparam int YF    = 100;
  localparam int RISE_T  = JH * JD;
  localparam int TOTAL_T = JH * (JD + FD);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_left = 1'b0;
  logic key_right = 1'b0;
  logic key_jump = 1'b0;
  logic [POS_W-1:0] xpos;
  logic [POS_W-1:0] ypos;
  logic dir;
  logic airborne;

  int n_pass = 0;
  int n_total = 0;

  player_motion #(
    .POS_W(POS_W), .STEP_DIV(SD), .JUMP_DIV(JD), .FALL_DIV(FD),
    .JUMP_HEIGHT(JH), .X_MIN(XMIN), .X_MAX(XMAX), .X_INIT(XINIT), .Y_FLOOR(YF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_left(key_left), .key_right(key_right),
    .key_jump(key_jump), .xpos(xpos), .ypos(ypos), .dir(dir), .airborne(airborne)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: walking edges counted in a run, air time in edges.
  int m_run, m_x, m_y, m_t;
  bit m_dir, m_air, m_prev;

  function automatic int y_at(input int t);
    if (t <= RISE_T) return YF - t / JD;
    return YF - JH + (t - RISE_T) / FD;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_x = XINIT; m_dir = 1'b1;
      m_air = 1'b0; m_t = 0; m_y = YF;
      m_prev = 1'b1;
    end else begin
      if (key_left != key_right) begin
        m_run++;
        m_dir = key_right;
        if (m_run % SD == 0) begin
          if (key_right && m_x < XMAX) m_x = m_x + 1;
          else if (!key_right && m_x > XMIN) m_x = m_x - 1;
        end
      end else begin
        m_run = 0;
      end
      if (m_air) begin
        m_t++;
        if (m_t >= TOTAL_T) m_air = 1'b0;
      end else if (key_jump && !m_prev) begin
        m_air = 1'b1;
        m_t = 0;
      end
      m_prev = key_jump;
      m_y = m_air ? y_at(m_t) : YF;
    end
  end

  always @(negedge clk) begin
    check("xpos", int'(xpos), m_x);
    check("ypos", int'(ypos), m_y);
    check("dir", int'(dir), int'(m_dir));
    check("airborne", int'(airborne), int'(m_air));
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    key_left = 1'b0; key_right = 1'b0; key_jump = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    edges(1);
  endtask

  initial begin
    // reset values
    do_reset();
    check("rst_x", int'(xpos), 12);
    check("rst_y", int'(ypos), 100);
    check("rst_dir", int'(dir), 1);
    check("rst_air", int'(airborne), 0);

    // 1: walk left into X_MIN
    key_left = 1'b1;
    edges(3);  check("s1_x_e3", int'(xpos), 12);
    edges(1);  check("s1_x_e4", int'(xpos), 11);
    edges(4);  check("s1_x_e8", int'(xpos), 10);
    edges(4);  check("s1_x_e12", int'(xpos), 10);
    check("s1_dir", int'(dir), 0);
    key_left = 1'b0;
    edges(2);

    // 2: single jump pulse
    do_reset();
    key_jump = 1'b1;
    edges(1);  key_jump = 1'b0;
    check("s2_air_e0", int'(airborne), 1);
    edges(2);  check("s2_y_e2", int'(ypos), 99);
    edges(8);  check("s2_y_e10", int'(ypos), 95);
    edges(3);  check("s2_y_e13", int'(ypos), 96);
    edges(11); check("s2_air_e24", int'(airborne), 1);
    check("s2_y_e24", int'(ypos), 99);
    edges(1);  check("s2_y_e25", int'(ypos), 100);
    check("s2_air_e25", int'(airborne), 0);
    edges(3);

    // 3: held jump key gives one jump; re-press gives another
    do_reset();
    key_jump = 1'b1;
    edges(1);  check("s3_air_e0", int'(airborne), 1);
    edges(59); check("s3_air_e59", int'(airborne), 0);
    check("s3_y_e59", int'(ypos), 100);
    key_jump = 1'b0;
    edges(1);  key_jump = 1'b1;
    edges(1);  check("s3_rejump", int'(airborne), 1);
    key_jump = 1'b0;
    edges(30);

    // 4: both keys held
    do_reset();
    key_left = 1'b1; key_right = 1'b1;
    edges(20); check("s4_x", int'(xpos), 12);
    check("s4_dir", int'(dir), 1);
    key_left = 1'b0; key_right = 1'b0;

    // 5: steering while airborne
    do_reset();
    key_jump = 1'b1;
    edges(1);  key_jump = 1'b0; key_right = 1'b1;
    edges(4);  check("s5_x_e4", int'(xpos), 13);
    check("s5_air_e4", int'(airborne), 1);
    edges(4);  check("s5_x_e8", int'(xpos), 14);
    edges(17); check("s5_x_e25", int'(xpos), 18);
    check("s5_y_e25", int'(ypos), 100);
    check("s5_air_e25", int'(airborne), 0);
    edges(40); check("s5_x_clamp", int'(xpos), 20);
    // reversal without a gap keeps the step phase
    do_reset();
    edges(0);
    key_left = 1'b0;
    edges(1);
    key_right = 1'b1;
    edges(3);  key_right = 1'b0; key_left = 1'b1;
    edges(1);  check("s5_rev_x", int'(xpos), 11);
    check("s5_rev_dir", int'(dir), 0);
    key_left = 1'b0;

    // 6: asynchronous reset mid-jump, held key must be re-pressed
    do_reset();
    key_jump = 1'b1;
    edges(1);  key_jump = 1'b0;
    edges(6);  check("s6_y_e6", int'(ypos), 97);
    key_jump = 1'b1; key_right = 1'b1;
    rst_n = 1'b0;
    #2;
    check("s6_rst_x", int'(xpos), 12);
    check("s6_rst_y", int'(ypos), 100);
    check("s6_rst_air", int'(airborne), 0);
    key_right = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    edges(10); check("s6_held_air", int'(airborne), 0);
    check("s6_held_y", int'(ypos), 100);
    key_jump = 1'b0;
    edges(1);  key_jump = 1'b1;
    edges(1);  check("s6_repress_air", int'(airborne), 1);
    key_jump = 1'b0;
    edges(30);

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
